// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and default timing constants for the digit scan controller.
//   scan_state_t      : controller state encoding (IDLE must stay at zero so
//                       the reset value of the state register is IDLE)
//   DEF_DWELL_CYCLES  : default cycles each digit is selected per visit
//   DEF_BLANK_CYCLES  : default blanking cycles between digits
// -----------------------------------------------------------------------------
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  localparam int DEF_DWELL_CYCLES = 4;
  localparam int DEF_BLANK_CYCLES = 2;

endpackage : scan_pkg

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter that times one DWELL or BLANK period.
// Loading N-1 gives a period of exactly N cycles: done is high during the
// last cycle of the period (count == 0). The counter holds at zero when it
// is not reloaded.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val on the next rising edge (has priority)
//   load_val : value to load (period length minus one)
//   done     : count has reached zero
// -----------------------------------------------------------------------------
module scan_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule : scan_timer

// File: rtl/digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl
// Time-multiplexed scan controller for a 4-digit display driven through a
// 2-to-4 decoder. Each digit is selected for DWELL_CYCLES cycles. Masked
// digits still take their full dwell time so all lit digits get the same
// duty cycle.
//
// Build option
//   SCAN_BLANK_EN defined   : a BLANK period of BLANK_CYCLES cycles (en=0,
//                             sel held) separates consecutive digits.
//   SCAN_BLANK_EN undefined : dwell periods run back to back; BLANK_CYCLES
//                             only sizes the timer.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset, forces IDLE and zero outputs
//   run        : level; 1 = scan, 0 = return to IDLE on the next edge
//   digit_mask : bit i = 1 lets digit i light
//   sel        : digit select (decoder x input), registered
//   en         : decoder enable, registered
//   frame_tick : one-cycle pulse on the first dwell cycle after a 3->0 wrap
//   busy       : high whenever the state is not IDLE, registered
// -----------------------------------------------------------------------------
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic       en,
  output logic       frame_tick,
  output logic       busy
);

  // Wide enough to hold the longer of the two period lengths.
  localparam int CNT_W =
    $clog2(((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif

  scan_state_t      state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_done;

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  // Next-state and next-output logic. Outputs are computed from the next
  // state so that they can be registered with no extra cycle of latency.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    tick_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    if (!run) begin
      // Stop from any state: clear the timer so a restart is a full period.
      state_d      = ST_IDLE;
      sel_d        = 2'd0;
      tmr_load     = 1'b1;
      tmr_load_val = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d      = ST_DWELL;
          sel_d        = 2'd0;
          tmr_load     = 1'b1;
          tmr_load_val = DWELL_LOAD;
        end

        ST_DWELL: begin
          if (tmr_done) begin
`ifdef SCAN_BLANK_EN
            state_d      = ST_BLANK;
            tmr_load     = 1'b1;
            tmr_load_val = BLANK_LOAD;
`else
            sel_d        = sel_q + 2'd1;
            tick_d       = (sel_q == 2'd3);
            tmr_load     = 1'b1;
            tmr_load_val = DWELL_LOAD;
`endif
          end
        end

`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (tmr_done) begin
            state_d      = ST_DWELL;
            sel_d        = sel_q + 2'd1;
            tick_d       = (sel_q == 2'd3);
            tmr_load     = 1'b1;
            tmr_load_val = DWELL_LOAD;
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
          sel_d   = 2'd0;
        end
      endcase
    end

    // The mask is sampled every cycle, so a change shows on en one cycle later.
    en_d   = (state_d == ST_DWELL) && digit_mask[sel_d];
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;

endmodule : digit_scan_ctrl

// File: tb/tb_digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_ctrl
// Directed bench for digit_scan_ctrl. A default-parameter instance is checked
// through start-up, full-frame scans with two masks, stop/restart, a mask
// change mid-dwell and an asynchronous reset. A second instance with
// DWELL_CYCLES=1, BLANK_CYCLES=1 is checked over the first scan window.
// Expected values follow from the scan timing: with the first dwell cycle
// numbered k=1 and PD cycles per digit visit, digit = ((k-1)/PD) mod 4, the
// first DWELL cycles of each visit are lit, and frame_tick marks k-1 being a
// nonzero multiple of 4*PD. Honours SCAN_BLANK_EN like the design.
// -----------------------------------------------------------------------------
module tb_digit_scan_ctrl;

  localparam int D0 = 4;
  localparam int B0 = 2;
  localparam int D1 = 1;
  localparam int B1 = 1;
`ifdef SCAN_BLANK_EN
  localparam int PD0 = D0 + B0;
  localparam int PD1 = D1 + B1;
`else
  localparam int PD0 = D0;
  localparam int PD1 = D1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] digit_mask;
  logic [1:0] sel, sel_f;
  logic       en, en_f;
  logic       frame_tick, tick_f;
  logic       busy, busy_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(
    .DWELL_CYCLES (D0),
    .BLANK_CYCLES (B0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .digit_mask (digit_mask),
    .sel        (sel),
    .en         (en),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  digit_scan_ctrl #(
    .DWELL_CYCLES (D1),
    .BLANK_CYCLES (B1)
  ) dut_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .digit_mask (digit_mask),
    .sel        (sel_f),
    .en         (en_f),
    .frame_tick (tick_f),
    .busy       (busy_f)
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int exp_sel(input int k, input int pd);
    return ((k - 1) / pd) % 4;
  endfunction

  function automatic int exp_en(input int k, input int d, input int pd, input logic [3:0] m);
    int idx;
    idx = k - 1;
    return ((idx % pd) < d && m[(idx / pd) % 4]) ? 1 : 0;
  endfunction

  function automatic int exp_tick(input int k, input int pd);
    return ((k - 1) != 0 && ((k - 1) % (4 * pd)) == 0) ? 1 : 0;
  endfunction

  // Checks the default instance at scan cycle k with expected mask m.
  task automatic check_cycle(input string tag, input int k, input logic [3:0] m);
    check({tag, ".sel"},  int'(sel),        exp_sel(k, PD0));
    check({tag, ".en"},   int'(en),         exp_en(k, D0, PD0, m));
    check({tag, ".tick"}, int'(frame_tick), exp_tick(k, PD0));
    check({tag, ".busy"}, int'(busy),       1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sel"},  int'(sel),        0);
    check({tag, ".en"},   int'(en),         0);
    check({tag, ".tick"}, int'(frame_tick), 0);
    check({tag, ".busy"}, int'(busy),       0);
  endtask

  initial begin
    logic [3:0] m;

    rst_n      = 1'b1;
    run        = 1'b0;
    digit_mask = 4'b1111;
    #2 rst_n   = 1'b0;
    #1 check_idle("reset");

    // Released with run=0: nothing may move.
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("idle_run0");
    end

    // Full scan, all digits enabled; fast instance checked alongside.
    run = 1'b1;
    for (int k = 1; k <= 4 * PD0 + 2; k++) begin
      @(negedge clk);
      check_cycle("scan_1111", k, 4'b1111);
      if (k <= 4 * PD1 + 2) begin
        check("fast.sel",  int'(sel_f),  exp_sel(k, PD1));
        check("fast.en",   int'(en_f),   exp_en(k, D1, PD1, 4'b1111));
        check("fast.tick", int'(tick_f), exp_tick(k, PD1));
      end
    end

    // Stop, then scan with digits 0 and 2 only.
    run = 1'b0;
    @(negedge clk) check_idle("stop1");
    digit_mask = 4'b0101;
    run        = 1'b1;
    for (int k = 1; k <= 4 * PD0 + 1; k++) begin
      @(negedge clk);
      check_cycle("scan_0101", k, 4'b0101);
    end

    // Stop during the last cycle of digit 2's visit, then restart.
    run = 1'b0;
    @(negedge clk) check_idle("stop2");
    digit_mask = 4'b1111;
    run        = 1'b1;
    for (int k = 1; k <= 3 * PD0; k++) begin
      @(negedge clk);
      check_cycle("pre_stop", k, 4'b1111);
    end
    run = 1'b0;
    @(negedge clk) check_idle("stop_mid");
    run = 1'b1;
    for (int k = 1; k <= D0 + 1; k++) begin
      @(negedge clk);
      check_cycle("restart", k, 4'b1111);
    end

    // Mask cleared during the second dwell cycle of digit 0.
    run = 1'b0;
    @(negedge clk) check_idle("stop3");
    run = 1'b1;
    m   = 4'b1111;
    for (int k = 1; k <= 4 * PD0 + 1; k++) begin
      @(negedge clk);
      check_cycle("mask_chg", k, m);
      if (k == 2) begin
        digit_mask = 4'b0000;
        m          = 4'b0000;
      end
    end

    // Asynchronous reset during digit 3's dwell, away from any clock edge.
    run = 1'b0;
    @(negedge clk) check_idle("stop4");
    digit_mask = 4'b1111;
    run        = 1'b1;
    for (int k = 1; k <= 3 * PD0 + 2; k++) begin
      @(negedge clk);
      check_cycle("pre_rst", k, 4'b1111);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= PD0 + 1; k++) begin
      @(negedge clk);
      check_cycle("post_rst", k, 4'b1111);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_digit_scan_ctrl

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, cycles each digit is selected per visit (legal >= 1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 2, blanking cycles between digits (legal >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port run  input  1  level; 1 = scan, 0 = stop and go idle.
REQ-006 SHALL have port digit_mask  input  4  per-digit enable; bit i = 1 lets digit i light.
REQ-007 SHALL have port sel  output  2  digit select, drives the 2-to-4 decoder x input.
REQ-008 SHALL have port en  output  1  decoder enable.
REQ-009 SHALL have port frame_tick  output  1  one-cycle pulse per completed 4-digit frame.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, DWELL, BLANK; all outputs registered.
REQ-012 IDLE: sel=0, en=0, busy=0; run=1 sampled at edge N -> DWELL, sel=0 from cycle N+1.
REQ-013 DWELL SHALL last exactly DWELL_CYCLES cycles; en = digit_mask[sel], sampled each cycle.
REQ-014 Masked digits SHALL still consume full DWELL time (uniform brightness), en=0 throughout.
REQ-015 End of DWELL -> BLANK (en=0, sel unchanged) for exactly BLANK_CYCLES cycles.
REQ-016 End of BLANK -> DWELL with sel = (sel+1) mod 4; 3 wraps to 0.
REQ-017 frame_tick SHALL be 1 for exactly the first DWELL cycle of sel=0 following a 3->0 wrap; never on start from IDLE.
REQ-018 run=0 sampled in any state -> IDLE next cycle, en=0, sel=0, counters cleared, no frame_tick.
REQ-019 run toggled 1->0->1 SHALL restart at sel=0 with a full DWELL period.
REQ-020 digit_mask change mid-DWELL SHALL affect en from the next cycle; timing unaffected.
REQ-021 Dwell/blank counter SHALL be $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits, no overflow.

Reset
REQ-022 rst_n=0 SHALL force IDLE, sel=0, en=0, frame_tick=0, busy=0 immediately, regardless of clk.
REQ-023 After rst_n deasserts, first state change SHALL occur on a rising edge with run=1.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined: BLANK state present per REQ-015.
REQ-025 SCAN_BLANK_EN undefined: no BLANK state; end of DWELL advances sel directly, en follows mask with no gap; BLANK_CYCLES ignored.

Structure
REQ-026 Package scan_pkg SHALL hold the state enum type and default DWELL_CYCLES/BLANK_CYCLES constants.
REQ-027 Sub-module scan_timer (loadable down-counter with done flag) SHALL time DWELL and BLANK.

Verification
REQ-028 Defaults, mask=4'b1111, run=1 at t0 -> sel 0,0,0,0(en=1),x,x(en=0),1,... ; 24-cycle frame; frame_tick at cycle 25 only.
REQ-029 mask=4'b0101 -> en high only while sel=0 or 2; sel sequence/timing identical to REQ-028.
REQ-030 run=0 mid-BLANK of sel=2 -> next cycle IDLE, sel=0, en=0, busy=0; run=1 again -> sel=0 full 4-cycle DWELL, no frame_tick.
REQ-031 rst_n=0 asynchronously mid-DWELL sel=3 -> outputs zero before next edge; no frame_tick after release.
REQ-032 SCAN_BLANK_EN undefined, DWELL_CYCLES=1 -> sel 0,1,2,3,0 on consecutive cycles, en constant 1, frame_tick every 4th cycle.
REQ-033 mask changed 1111->0000 on cycle 2 of DWELL -> en=0 from cycle 3; sel advance unchanged.
